// File: rtl/nx_dot_accum_int8_if.sv
// Handshake bundle between the chunk source / dot-product unit and the
// vector accumulator. The master side presents chunk tags and the upstream
// dot-product result; the slave side (the accumulator) returns the vector
// result and status.
interface nx_dot_accum_int8_if #(
   parameter int DIN_W = 20,
   parameter int OUT_W = 32
);
   logic                    in_valid;
   logic                    in_first;
   logic                    in_last;
   logic signed [DIN_W-1:0] dot_dout;
   logic                    out_valid;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_sat;
   logic                    err;
   logic                    busy;

   modport master (
      output in_valid, in_first, in_last, dot_dout,
      input  out_valid, out_data, out_sat, err, busy
   );

   modport slave (
      input  in_valid, in_first, in_last, dot_dout,
      output out_valid, out_data, out_sat, err, busy
   );
endinterface

// File: rtl/nx_dot_accum_int8.sv
// Vector accumulator placed behind the int8 dot-product unit. Chunk tags are
// delayed to line up with the upstream result, chunk results are summed per
// vector with wrap-around at ACC_W, and one saturated OUT_W result is emitted
// per vector together with a sticky protocol-error flag.
module nx_dot_accum_int8 #(
   parameter int NUM         = 16,
   parameter int DOT_LATENCY = 4 + $clog2((NUM - 1) / 6 + 1),
   parameter int DIN_W       = 16 + $clog2(NUM),
   parameter int ACC_W       = 32,
   parameter int OUT_W       = 32
) (
   input logic               clk,
   input logic               rst,
   nx_dot_accum_int8_if.slave bus
);
   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                  state;
   logic [DOT_LATENCY-1:0]  vld_pipe;
   logic [DOT_LATENCY-1:0]  fst_pipe;
   logic [DOT_LATENCY-1:0]  lst_pipe;
   logic                    v;
   logic                    f;
   logic                    l;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] d;
   logic signed [ACC_W-1:0] sum;
   logic signed [OUT_W-1:0] nar;
   logic                    nar_sat;
   logic                    out_valid_q;
   logic signed [OUT_W-1:0] out_data_q;
   logic                    out_sat_q;
   logic                    err_q;

   // Valid tags travel down the delay line; only these are cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= bus.in_valid;
         for (int i = 1; i < DOT_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   // First/last tags ride alongside; they are meaningless without a valid bit
   always_ff @(posedge clk) begin
      fst_pipe[0] <= bus.in_first;
      lst_pipe[0] <= bus.in_last;
      for (int i = 1; i < DOT_LATENCY; i++) begin
         fst_pipe[i] <= fst_pipe[i-1];
         lst_pipe[i] <= lst_pipe[i-1];
      end
   end

   assign v = vld_pipe[DOT_LATENCY-1];
   assign f = fst_pipe[DOT_LATENCY-1];
   assign l = lst_pipe[DOT_LATENCY-1];

   // A first chunk restarts the sum, which also discards a dangling partial sum
   assign d   = ACC_W'(bus.dot_dout);
   assign sum = f ? d : acc + d;

   generate
      if (OUT_W < ACC_W) begin : g_narrow
         localparam int HI_W = ACC_W - OUT_W + 1;
         logic [HI_W-1:0] top;

         assign top = sum[ACC_W-1:OUT_W-1];

         // Clip to the OUT_W range whenever the dropped high bits are not pure sign
         always_comb begin
            nar     = sum[OUT_W-1:0];
            nar_sat = 1'b0;
            if (!((top == '0) || (top == '1))) begin
               nar_sat = 1'b1;
               if (sum[ACC_W-1]) begin
                  nar = {1'b1, {(OUT_W-1){1'b0}}};
               end else begin
                  nar = {1'b0, {(OUT_W-1){1'b1}}};
               end
            end
         end
      end else begin : g_full
         assign nar     = sum;
         assign nar_sat = 1'b0;
      end
   endgenerate

   // Vector state machine: accumulate aligned chunks and register the result on last
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (v) begin
            if ((f && state == ACCUM) || (!f && state == IDLE)) begin
               err_q <= 1'b1;
            end
            if (l) begin
               out_valid_q <= 1'b1;
               out_data_q  <= nar;
               out_sat_q   <= nar_sat;
               acc         <= '0;
               state       <= IDLE;
            end else begin
               acc   <= sum;
               state <= ACCUM;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.err       = err_q;
   assign bus.busy      = (|vld_pipe) | (state == ACCUM);
endmodule

// File: tb/tb_nx_dot_accum_int8.sv
// Self-checking bench for nx_dot_accum_int8. Two instances share one stimulus
// stream: one with default widths and one narrowed to a 20-bit output so that
// saturation is reachable. The upstream dot-product unit is modelled as a pure
// delay of a chunk value computed from int8 lane operands.
module tb_nx_dot_accum_int8;
   localparam int NUM    = 16;
   localparam int LAT    = 4 + $clog2((NUM - 1) / 6 + 1);
   localparam int DIN_W  = 16 + $clog2(NUM);
   localparam int ACC_W  = 32;
   localparam int OUT_W  = 32;
   localparam int OUT_WS = 20;

   typedef struct {
      int     cyc;
      longint d_full;
      longint d_narrow;
      bit     s_narrow;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_first = 1'b0;
   logic                    in_last = 1'b0;
   logic signed [DIN_W-1:0] dot_dout;
   logic signed [DIN_W-1:0] dsched [64];
   int                      cyc = 0;
   int                      n_checks = 0;
   int                      n_errors = 0;
   int                      out_count = 0;
   longint                  last_full = 0;
   longint                  last_narrow = 0;
   bit                      last_sat = 1'b0;
   bit                      m_open = 1'b0;
   bit                      m_err = 1'b0;
   longint                  m_sum = 0;
   exp_t                    expq [$];
   exp_t                    mon_e;
   bit                      mon_hit;

   nx_dot_accum_int8_if #(.DIN_W(DIN_W), .OUT_W(OUT_W))  bus ();
   nx_dot_accum_int8_if #(.DIN_W(DIN_W), .OUT_W(OUT_WS)) bus_s ();

   assign bus.in_valid   = in_valid;
   assign bus.in_first   = in_first;
   assign bus.in_last    = in_last;
   assign bus.dot_dout   = dot_dout;
   assign bus_s.in_valid = in_valid;
   assign bus_s.in_first = in_first;
   assign bus_s.in_last  = in_last;
   assign bus_s.dot_dout = dot_dout;

   nx_dot_accum_int8 #(
      .NUM(NUM), .DOT_LATENCY(LAT), .DIN_W(DIN_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   nx_dot_accum_int8 #(
      .NUM(NUM), .DOT_LATENCY(LAT), .DIN_W(DIN_W), .ACC_W(ACC_W), .OUT_W(OUT_WS)
   ) dut_s (
      .clk(clk),
      .rst(rst),
      .bus(bus_s)
   );

   // Free-running clock and cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Upstream unit: each cycle's result was scheduled LAT cycles earlier
   assign dot_dout = dsched[cyc % 64];

   task automatic check_output(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Sign-wrap an unbounded sum into the ACC_W two's-complement range
   function automatic longint wrap_acc(input longint x);
      longint m;
      longint r;
      m = longint'(1) << ACC_W;
      r = x % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   // Clip to a w-bit signed range and report whether clipping happened
   function automatic longint sat_to(input longint x, input int w, output bit s);
      longint lim;
      lim = longint'(1) << (w - 1);
      s = 1'b1;
      if (x > lim - 1) return lim - 1;
      if (x < -lim) return -lim;
      s = 1'b0;
      return x;
   endfunction

   function automatic longint dot_uniform(input int a, input int b);
      longint s = 0;
      for (int i = 0; i < NUM; i++) s += longint'(a) * longint'(b);
      return s;
   endfunction

   function automatic longint dot_random();
      longint s = 0;
      int a;
      int b;
      for (int i = 0; i < NUM; i++) begin
         a = int'($urandom_range(0, 255)) - 128;
         b = int'($urandom_range(0, 255)) - 128;
         s += longint'(a) * longint'(b);
      end
      return s;
   endfunction

   // Present one cycle of input, schedule its upstream result and update the model
   task automatic apply_stimulus(input bit v, input bit f, input bit l, input longint d);
      exp_t e;
      bit s;
      in_valid = v;
      in_first = f;
      in_last  = l;
      dsched[(cyc + LAT) % 64] = v ? DIN_W'(d) : DIN_W'($urandom);
      if (v) begin
         if ((f && m_open) || (!f && !m_open)) m_err = 1'b1;
         m_sum = f ? d : m_sum + d;
         if (l) begin
            e.cyc      = cyc + LAT + 1;
            e.d_full   = sat_to(wrap_acc(m_sum), OUT_W, s);
            e.d_narrow = sat_to(wrap_acc(m_sum), OUT_WS, e.s_narrow);
            expq.push_back(e);
            m_sum  = 0;
            m_open = 1'b0;
         end else begin
            m_open = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 0);
      rst = 1'b0;
      m_open = 1'b0;
      m_sum  = 0;
      m_err  = 1'b0;
      expq.delete();
      out_count = 0;
   endtask

   task automatic send_vector(input int n, input int a, input int b, input int gap);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b1, i == 0, i == n - 1, dot_uniform(a, b));
         if (i != n - 1) idle(gap);
      end
   endtask

   task automatic check_status(input string tag, input bit err_exp, input bit busy_exp);
      check_output({tag, "_err"}, bus.err, err_exp);
      check_output({tag, "_err_s"}, bus_s.err, err_exp);
      check_output({tag, "_busy"}, bus.busy, busy_exp);
      check_output({tag, "_busy_s"}, bus_s.busy, busy_exp);
   endtask

   // Output monitor: every result must appear exactly in its expected cycle
   always @(negedge clk) begin
      if (!rst) begin
         mon_hit = (expq.size() > 0) && (expq[0].cyc == cyc);
         if (mon_hit || bus.out_valid || bus_s.out_valid) begin
            check_output("out_valid", bus.out_valid, mon_hit);
            check_output("out_valid_s", bus_s.out_valid, mon_hit);
            if (bus.out_valid) out_count++;
            if (mon_hit) begin
               mon_e = expq.pop_front();
               check_output("out_data", bus.out_data, mon_e.d_full);
               check_output("out_sat", bus.out_sat, 0);
               check_output("out_data_s", bus_s.out_data, mon_e.d_narrow);
               check_output("out_sat_s", bus_s.out_sat, mon_e.s_narrow);
               last_full   = bus.out_data;
               last_narrow = bus_s.out_data;
               last_sat    = bus_s.out_sat;
            end
         end
         if ((expq.size() > 0) && (expq[0].cyc < cyc)) begin
            mon_e = expq.pop_front();
            check_output("missed_result", 0, 1);
         end
      end
   end

   // Directed scenarios followed by a randomized regression
   initial begin
      int len;
      for (int i = 0; i < 64; i++) dsched[i] = '0;
      #1;
      do_reset(2);
      check_output("rst_out_valid", bus.out_valid, 0);
      check_output("rst_out_data", bus.out_data, 0);
      check_output("rst_out_sat", bus.out_sat, 0);
      check_output("rst_out_data_s", bus_s.out_data, 0);
      check_output("rst_out_sat_s", bus_s.out_sat, 0);
      check_status("rst", 1'b0, 1'b0);

      send_vector(1, 127, 127, 0);
      idle(LAT + 2);
      check_output("single_data", last_full, 258064);
      check_output("single_count", out_count, 1);

      send_vector(4, -128, -128, 0);
      idle(5);
      check_output("multi_busy_open", bus.busy, 1);
      idle(1);
      check_output("multi_busy_done", bus.busy, 0);
      idle(2);
      check_output("multi_data", last_full, 1048576);

      send_vector(4, -128, -128, 3);
      idle(LAT + 2);
      check_output("gapped_data", last_full, 1048576);

      send_vector(4, 127, 127, 1);
      idle(LAT + 2);
      check_output("sat_pos_data", last_narrow, 524287);
      check_output("sat_pos_flag", last_sat, 1);
      check_output("sat_pos_full", last_full, 1032256);

      send_vector(4, -128, 127, 0);
      idle(LAT + 2);
      check_output("sat_neg_data", last_narrow, -524288);
      check_output("sat_neg_flag", last_sat, 1);
      check_status("clean", 1'b0, 1'b0);

      do_reset(1);
      apply_stimulus(1'b1, 1'b1, 1'b0, 100);
      apply_stimulus(1'b1, 1'b1, 1'b0, 200);
      apply_stimulus(1'b1, 1'b0, 1'b1, 300);
      idle(LAT + 2);
      check_output("err_refirst_data", last_full, 500);
      check_status("err_refirst", 1'b1, 1'b0);

      do_reset(1);
      apply_stimulus(1'b1, 1'b0, 1'b0, 700);
      idle(2);
      apply_stimulus(1'b1, 1'b0, 1'b1, -50);
      idle(LAT + 2);
      check_output("err_nofirst_data", last_full, 650);
      check_status("err_nofirst", 1'b1, 1'b0);

      do_reset(1);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1000);
      apply_stimulus(1'b1, 1'b0, 1'b0, 2000);
      do_reset(1);
      check_status("midrst", 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b1, 77);
      idle(LAT + 4);
      check_output("midrst_count", out_count, 1);
      check_output("midrst_data", last_full, 77);
      check_status("midrst_end", 1'b0, 1'b0);

      for (int vec = 0; vec < 10000; vec++) begin
         len = int'($urandom_range(1, 8));
         for (int i = 0; i < len; i++) begin
            apply_stimulus(1'b1, i == 0, i == len - 1, dot_random());
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
         end
      end
      idle(LAT + 3);
      check_output("rand_pending", expq.size(), 0);
      check_status("rand_end", 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/nx_dot_accum_int8.md
# nx_dot_accum_int8

Accumulator stage that sits directly downstream of the int8 dot-product unit (`nx_dot_product_int8`). It carries per-operation tags (valid/first/last) through a delay line matched to the dot-product latency, sums successive dot-product results belonging to one long vector, and emits one narrowed, saturated result per vector. Together with the dot-product unit it forms a dot-product engine for vectors longer than NUM elements.

## Interface
Parameters:
- `NUM`, 16: elements per dot-product chunk; must match the upstream unit.
- `DOT_LATENCY`, 4+$clog2((NUM-1)/6+1): latency of the upstream unit, in cycles. Must be ≥1. The default is 6 for NUM=16.
- `DIN_W`, 16+$clog2(NUM): width of the upstream result. The default is 20.
- `ACC_W`, 32: accumulator width. Must satisfy ACC_W ≥ DIN_W.
- `OUT_W`, 32: output width. Must satisfy OUT_W ≤ ACC_W.

Ports:
- `clk` in 1: clock. This is the only clock in the block.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: a chunk is presented to the dot-product unit in this cycle.
- `in_first` in 1: this chunk opens a new vector. Qualified by `in_valid`.
- `in_last` in 1: this chunk closes the vector. Qualified by `in_valid`.
- `dot_dout` in DIN_W, signed: dot-product result. Arrives DOT_LATENCY cycles after its chunk.
- `out_valid` out 1: one-cycle pulse that marks a finished vector result.
- `out_data` out OUT_W, signed: the vector sum, saturated to OUT_W.
- `out_sat` out 1: set when `out_data` was clipped. Qualified by `out_valid`.
- `err` out 1: sticky protocol-error flag.
- `busy` out 1: a tag is in flight or a vector is open.

## Operation
Tag delay line:
- The tuple {in_valid, in_first, in_last} passes through a DOT_LATENCY-deep shift register.
- The tuple taken in at cycle t is aligned with `dot_dout` at cycle t+DOT_LATENCY. Call the aligned tags `v`, `f`, `l`.
- `rst` clears only the valid bits of the delay line.

State machine (`open` flag):
- IDLE: no vector in progress. `acc` = 0.
- ACCUM: a vector has started and its last chunk has not been seen.

At each aligned cycle with `v`=1, let `d` = sign-extend(dot_dout) to ACC_W:
- `f`=1: `sum` = d.
- `f`=0: `sum` = acc + d. Two's-complement add that wraps at ACC_W.
- `l`=0: acc ← sum and the state becomes ACCUM.
- `l`=1: the output register is loaded from sum, acc ← 0, and the state becomes IDLE.
- `f`=1 and `l`=1 together form a single-chunk vector.

When `v`=0, acc and state hold. Gaps of any length between chunks are legal.

Protocol errors set `err`, which stays set until `rst`:
- `f`=1 while in ACCUM: the partial sum is discarded and the new vector starts from d.
- `f`=0 while in IDLE: the vector starts from acc = 0, i.e. sum = d.

Output narrowing:
- If sum > 2^(OUT_W-1)-1, `out_data` = 2^(OUT_W-1)-1 and `out_sat` = 1.
- If sum < -2^(OUT_W-1), `out_data` = -2^(OUT_W-1) and `out_sat` = 1.
- Otherwise `out_data` = sum[OUT_W-1:0] and `out_sat` = 0.
- When OUT_W = ACC_W, `out_sat` is always 0.

`busy` = (OR of the delay-line valid bits) | (state==ACCUM).

## Timing
Latency:
- Chunk presented at cycle t: its aligned cycle is t+DOT_LATENCY.
- `out_valid` rises at t+DOT_LATENCY+1 for the last chunk. That is cycle t+7 with the default parameters.
- The full chunk rate is accepted: one chunk per cycle, back-to-back, with no stalls.
- A new vector may start at the aligned cycle immediately after a `l` cycle.
- There is no backpressure. `out_valid` is a single-cycle pulse.
- `out_data` and `out_sat` hold their values until the next `out_valid`.

Reset values (at the first edge with `rst`=1):
- `out_valid`=0, `out_data`=0, `out_sat`=0, `err`=0, `busy`=0.
- acc=0, state=IDLE, all delay-line valid bits = 0.

Reset mid-operation:
- Tags in flight and any partial sum are lost.
- No `out_valid` follows for chunks issued before reset, even though `dot_dout` still carries their data (the upstream unit is not reset).
- Chunks issued in the cycle after `rst` deasserts are processed normally.

`rst` has priority over all other events in the same cycle.

## Test plan
- **Single-chunk vector** (defaults). At t=0 drive a=b=127 for all 16 lanes with first=last=1. Required: `out_valid` at t=7 only, `out_data`=258064, `out_sat`=0.
- **Multi-chunk, back-to-back, then gapped.** Four chunks with a=b=-128 in cycles 0..3, first on cycle 0, last on cycle 3. Required: `out_data`=1048576 at cycle 10 and `busy`=0 from cycle 10. Repeat the same vector with idle cycles between chunks: identical result.
- **Saturation** (OUT_W=20). Four chunks of a=b=127: required 524287 with `out_sat`=1. Four chunks of a=-128, b=127: required -524288 with `out_sat`=1.
- **Protocol errors.** Send first, then first again without a last, then last; with chunk sums of 100, 200, 300 the required result is 500 and `err`=1. In a second test from a clean reset, send a chunk without first, then a last chunk; required: the result equals the sum of those two chunks and `err`=1.
- **Reset mid-vector.** Chunks 1–2 of a vector, then `rst` for 1 cycle, then a fresh single-chunk vector. Required: exactly one `out_valid`, carrying only the fresh chunk's value, and `err`=0.
- **Random regression.** Random vector lengths 1–8, random gaps, random int8 operands. Compare against a reference model using ACC_W wrap and OUT_W saturation, over ≥10k vectors.
